// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, registered read data and sticky error flags.
module param_sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             ra;
    logic             wa;

    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_empty = (count <= CW'(AEMPTY_TH));
    assign almost_full  = (count >= CW'(AFULL_TH));

    // A read on a full FIFO frees the slot the simultaneous write needs.
    assign ra = rd && !empty;
    assign wa = wr && (!full || rd);

    // Storage is never cleared; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!rst && wa) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wa) begin
                wptr <= wptr + AW'(1);
            end
            if (ra) begin
                dout <= mem[rptr];
                rptr <= rptr + AW'(1);
            end
            dout_valid <= ra;

            case ({wa, ra})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // A fresh error in the same cycle as err_clr keeps the flag set.
            if (wr && full && !rd) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard testbench for param_sync_fifo: a queue-based reference model tracks
// contents and flags, and a monitor compares DUT outputs every cycle.
module tb_param_sync_fifo;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int AFULL_TH  = DEPTH - 4;
    localparam int AEMPTY_TH = 4;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr = 1'b0;
    logic             rd = 1'b0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    param_sync_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) dut (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd),
        .dout(dout), .dout_valid(dout_valid), .count(count),
        .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .overflow(overflow), .underflow(underflow),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Reference model state: what the FIFO should look like after the last edge.
    logic [WIDTH-1:0] mdl_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] mdl_dout = '0;
    logic             mdl_valid = 1'b0;
    logic             mdl_ovf = 1'b0;
    logic             mdl_unf = 1'b0;
    bit               started = 1'b0;

    int checks = 0;
    int failures = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, $time, act, act, exp, exp);
        end
    endfunction

    // Drive one cycle of requests, then advance the model across the edge.
    task automatic applyStimulus(input logic r_rst, input logic r_wr, input logic [WIDTH-1:0] r_din,
                                 input logic r_rd, input logic r_clr);
        bit was_full, was_empty, ra, wa;
        logic [WIDTH-1:0] d;
        rst = r_rst; wr = r_wr; din = r_din; rd = r_rd; err_clr = r_clr;
        @(posedge clk);
        if (r_rst) begin
            mdl_q.delete();
            mdl_dout  = '0;
            mdl_valid = 1'b0;
            mdl_ovf   = 1'b0;
            mdl_unf   = 1'b0;
        end else begin
            was_full  = (mdl_q.size() == DEPTH);
            was_empty = (mdl_q.size() == 0);
            ra = r_rd && !was_empty;
            wa = r_wr && (!was_full || r_rd);
            if (ra) begin
                d = mdl_q.pop_front();
                exp_q.push_back(d);
                mdl_dout = d;
            end
            if (wa) mdl_q.push_back(r_din);
            mdl_valid = ra;
            if (r_wr && was_full && !r_rd) mdl_ovf = 1'b1;
            else if (r_clr) mdl_ovf = 1'b0;
            if (r_rd && was_empty) mdl_unf = 1'b1;
            else if (r_clr) mdl_unf = 1'b0;
        end
        #1;
    endtask

    task automatic checkOutput();
        int n;
        n = mdl_q.size();
        check("dout_valid", int'(dout_valid), int'(mdl_valid));
        if (dout_valid) begin
            if (exp_q.size() == 0) begin
                check("dout_valid_unexpected", 1, 0);
            end else begin
                check("dout_scoreboard", int'(dout), int'(exp_q.pop_front()));
            end
        end
        check("dout_hold", int'(dout), int'(mdl_dout));
        check("count", int'(count), n);
        check("empty", int'(empty), int'(n == 0));
        check("full", int'(full), int'(n == DEPTH));
        check("almost_empty", int'(almost_empty), int'(n <= AEMPTY_TH));
        check("almost_full", int'(almost_full), int'(n >= AFULL_TH));
        check("overflow", int'(overflow), int'(mdl_ovf));
        check("underflow", int'(underflow), int'(mdl_unf));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (started) checkOutput();
        end
    end

    initial begin
        int wr_pct;
        int rd_pct;
        applyStimulus(1, 0, '0, 0, 0);
        applyStimulus(1, 0, '0, 0, 0);
        started = 1'b1;

        // Fill to full, then one rejected write.
        for (int i = 1; i <= DEPTH; i++) applyStimulus(0, 1, WIDTH'(i), 0, 0);
        applyStimulus(0, 1, 8'hEE, 0, 0);
        // Drain, then one rejected read.
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, '0, 1, 0);
        applyStimulus(0, 0, '0, 1, 0);
        applyStimulus(0, 0, '0, 0, 1);
        applyStimulus(0, 0, '0, 0, 0);

        // Wrap-around through the end of the array.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) applyStimulus(0, 1, WIDTH'(8'h20 + k * 16 + i), 0, 0);
            for (int i = 0; i < 10; i++) applyStimulus(0, 0, '0, 1, 0);
        end

        // Full with simultaneous read and write.
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, WIDTH'(8'h60 + i), 0, 0);
        applyStimulus(0, 1, 8'hAA, 1, 0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, '0, 1, 0);

        // Empty with simultaneous read and write.
        applyStimulus(0, 1, 8'h55, 1, 0);
        applyStimulus(0, 0, '0, 1, 0);
        applyStimulus(0, 0, '0, 0, 1);

        // Reset mid-stream, then clear colliding with a new underflow.
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, WIDTH'(8'h70 + i), 0, 0);
        applyStimulus(1, 1, 8'h99, 1, 0);
        applyStimulus(0, 0, '0, 1, 1);
        applyStimulus(0, 1, 8'h3C, 0, 0);
        applyStimulus(0, 0, '0, 1, 0);

        // Randomized traffic with shifting read/write bias.
        for (int c = 0; c < 3000; c++) begin
            case ((c / 300) % 4)
                0:       begin wr_pct = 75; rd_pct = 35; end
                1:       begin wr_pct = 30; rd_pct = 75; end
                2:       begin wr_pct = 50; rd_pct = 50; end
                default: begin wr_pct = 90; rd_pct = 90; end
            endcase
            applyStimulus(($urandom_range(0, 399) == 0),
                          ($urandom_range(0, 99) < wr_pct),
                          WIDTH'($urandom),
                          ($urandom_range(0, 99) < rd_pct),
                          ($urandom_range(0, 19) == 0));
        end

        applyStimulus(0, 0, '0, 0, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
